// File: rtl/alu64_seq.sv
// Two-cycle 64-bit Y86-64 ALU sequencer: one 32-bit add/sub/and/xor slice reused for low then high half.
// Define ALU_SEQ_LOGIC_BYPASS_EN to finish andq/xorq in a single cycle straight from IDLE.
module alu64_seq #(
    parameter int unsigned SLICE_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             op,
    input  logic [2*SLICE_W-1:0]   a,
    input  logic [2*SLICE_W-1:0]   b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*SLICE_W-1:0]   result,
    output logic [2:0]             cc
);

    localparam int unsigned W = 2 * SLICE_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t               state;
    logic [1:0]           op_r;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic [SLICE_W-1:0]   lo_r;
    logic                 carry_r;

    logic [SLICE_W-1:0]   sl_a;
    logic [SLICE_W-1:0]   sl_b;
    logic                 sl_cin;
    logic [SLICE_W:0]     sl_sum;
    logic [SLICE_W-1:0]   sl_res;
    logic                 sl_cout;

    logic [W-1:0]         full_res;
    logic                 full_of;

    // {ZF,SF,OF} for a full-width result
    function automatic logic [2:0] flags(input logic [W-1:0] r, input logic of);
        return {(r == '0), r[W-1], of};
    endfunction

    // Shared slice: the half is selected by state, carry-in comes from the LO pass in HI
    always_comb begin
        sl_a    = (state == HI) ? a_r[W-1:SLICE_W] : a_r[SLICE_W-1:0];
        sl_b    = (state == HI) ? b_r[W-1:SLICE_W] : b_r[SLICE_W-1:0];
        if (op_r == OP_SUB) begin
            sl_b = ~sl_b;
        end
        sl_cin  = (state == HI) ? carry_r : (op_r == OP_SUB);
        sl_sum  = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE_W{1'b0}}, sl_cin};
        sl_res  = sl_sum[SLICE_W-1:0];
        sl_cout = sl_sum[SLICE_W];
        case (op_r)
            OP_AND: begin
                sl_res  = sl_a & sl_b;
                sl_cout = 1'b0;
            end
            OP_XOR: begin
                sl_res  = sl_a ^ sl_b;
                sl_cout = 1'b0;
            end
            default: ;
        endcase
    end

    // Assembled 64-bit result and signed overflow, meaningful during HI
    always_comb begin
        full_res = {sl_res, lo_r};
        full_of  = 1'b0;
        case (op_r)
            OP_ADD:  full_of = (a_r[W-1] == b_r[W-1]) && (full_res[W-1] != a_r[W-1]);
            OP_SUB:  full_of = (a_r[W-1] != b_r[W-1]) && (full_res[W-1] != a_r[W-1]);
            default: full_of = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_LOGIC_BYPASS_EN
    logic [W-1:0] byp_res;

    always_comb begin
        byp_res = op[0] ? (a ^ b) : (a & b);
    end
`endif

    // Sequencer; req_ready/res_valid are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            result    <= '0;
            cc        <= CC_RESET;
            op_r      <= OP_ADD;
            a_r       <= '0;
            b_r       <= '0;
            lo_r      <= '0;
            carry_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r      <= op;
                        a_r       <= a;
                        b_r       <= b;
                        carry_r   <= 1'b0;
                        req_ready <= 1'b0;
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
                        if (op[1]) begin
                            result    <= byp_res;
                            cc        <= flags(byp_res, 1'b0);
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= LO;
                        end
`else
                        state <= LO;
`endif
                    end
                end
                LO: begin
                    lo_r    <= sl_res;
                    carry_r <= sl_cout;
                    state   <= HI;
                end
                HI: begin
                    result    <= full_res;
                    cc        <= flags(full_res, full_of);
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu64_seq.sv
// Scoreboard bench for alu64_seq: directed corner cases, back-pressure, mid-op reset, random ops.
// Honours ALU_SEQ_LOGIC_BYPASS_EN for the expected latency of andq/xorq.
module tb_alu64_seq;

`ifdef ALU_SEQ_LOGIC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] result;
    logic [2:0]  cc;

    logic rdy_manual;
    logic rdy_rand_mode;
    logic rdy_rand;

    assign res_ready = rdy_rand_mode ? rdy_rand : rdy_manual;

    alu64_seq #(.SLICE_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .cc        (cc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] r;
        logic [2:0]  cc;
        int          lat;
        int          c0;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
        return (BYPASS && o[1]) ? 1 : 3;
    endfunction

    // Reference: plain 64-bit arithmetic and the architectural flag rules
    function automatic exp_t model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        logic [63:0] r;
        logic of;
        of = 1'b0;
        case (o)
            2'd0: begin r = x + y; of = (x[63] == y[63]) && (r[63] != x[63]); end
            2'd1: begin r = x - y; of = (x[63] != y[63]) && (r[63] != x[63]); end
            2'd2: r = x & y;
            default: r = x ^ y;
        endcase
        e.r    = r;
        e.cc   = {(r == 64'd0), r[63], of};
        e.lat  = lat_of(o);
        e.c0   = 0;
        e.name = "rand";
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] er, input logic [2:0] ec, input string name);
        exp_t e;
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        op = o; a = x; b = y; req_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e.r = er; e.cc = ec; e.lat = lat_of(o); e.c0 = cyc; e.name = name;
                sb.push_back(e);
                got = 1'b1;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: accept timeout, req_ready=%b required 1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        op = 2'($urandom_range(0, 3));
        a  = {$urandom(), $urandom()};
        b  = {$urandom(), $urandom()};
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && req_ready) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: drain timeout, pending=%0d required 0", name, sb.size());
        end
    endtask

    // Monitor: compare on the first cycle of res_valid, then require stability while held
    initial begin
        exp_t e;
        logic        prev;
        logic [63:0] held_r;
        logic [2:0]  held_cc;
        prev = 1'b0; held_r = '0; held_cc = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev = 1'b0;
            end else begin
                if (res_valid && !prev) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got %h with no pending op", result);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_result"}, result, e.r);
                        check({e.name, "_cc"}, 64'(cc), 64'(e.cc));
                        check({e.name, "_latency"}, 64'(cyc - e.c0), 64'(e.lat));
                    end
                    held_r  = result;
                    held_cc = cc;
                end else if (res_valid && prev) begin
                    check("hold_result", result, held_r);
                    check("hold_cc", 64'(cc), 64'(held_cc));
                end
                prev = res_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            rdy_rand = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        bit   seen;
        logic [1:0]  ro;
        logic [63:0] rx;
        logic [63:0] ry;

        rst_n = 1'b1; req_valid = 1'b0; op = '0; a = '0; b = '0;
        rdy_manual = 1'b1; rdy_rand_mode = 1'b0; rdy_rand = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_result", result, 64'h0);
        check("reset_cc", 64'(cc), 64'(3'b100));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(2'd0, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 3'b000, "add_carry");
        drain("add_carry");
        issue(2'd1, 64'd5, 64'd5, 64'h0, 3'b100, "sub_zero");
        drain("sub_zero");
        issue(2'd1, 64'd0, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 3'b010, "sub_neg");
        drain("sub_neg");
        issue(2'd0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 3'b011, "add_ovf");
        drain("add_ovf");
        issue(2'd1, 64'h80000000_00000000, 64'h1, 64'h7FFFFFFF_FFFFFFFF, 3'b001, "sub_ovf");
        drain("sub_ovf");
        issue(2'd2, 64'hFFFFFFFF_FFFFFFF5, 64'hD, 64'h5, 3'b000, "and");
        drain("and");
        issue(2'd3, 64'h1234, 64'h1234, 64'h0, 3'b100, "xor_zero");
        drain("xor_zero");

        // Back-pressure in DONE with a new request waiting
        rdy_manual = 1'b0;
        issue(2'd0, 64'd3, 64'd4, 64'd7, 3'b000, "hold_first");
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("hold_reach_done", 64'(seen), 64'd1);
        @(posedge clk); #1;
        op = 2'd1; a = 64'd3; b = 64'd10; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_res_valid", 64'(res_valid), 64'd1);
        end
        @(posedge clk); #1;
        rdy_manual = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (req_ready) begin
                seen = 1'b1;
                e.r = 64'hFFFFFFFF_FFFFFFF9; e.cc = 3'b010; e.lat = 3; e.c0 = cyc; e.name = "hold_second";
                sb.push_back(e);
            end
        end
        check("hold_accept_delay", 64'(n), 64'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain("hold_second");

        // Reset while the adder is in its high-half pass
        issue(2'd3, 64'hF0, 64'h0F, 64'hFF, 3'b000, "pre_reset");
        drain("pre_reset");
        issue(2'd0, 64'hFFFFFFFF, 64'h1, 64'h1_00000000, 3'b000, "dropped");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_res_valid", 64'(res_valid), 64'd0);
        check("midreset_result", result, 64'h0);
        check("midreset_cc", 64'(cc), 64'(3'b100));
        check("midreset_req_ready", 64'(req_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd0, 64'd5, 64'd7, 64'd12, 3'b000, "post_reset");
        drain("post_reset");
        repeat (4) @(negedge clk);
        check("no_stale_result", 64'(sb.size()), 64'd0);

        // Random operations with random consumer back-pressure
        rdy_rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = {$urandom(), $urandom()};
            ry = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: rx = 64'h7FFFFFFF_FFFFFFFF;
                1: ry = 64'h80000000_00000000;
                2: ry = rx;
                3: rx = {32'h0, 32'hFFFFFFFF};
                default: ;
            endcase
            e = model(ro, rx, ry);
            issue(ro, rx, ry, e.r, e.cc, "rand");
        end
        drain("rand");
        rdy_rand_mode = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
